bitwise_pipe: RTL
=================

// Module: bitwise_pipe
// PURPOSE
//  Parametrised, buffered successor to the fixed 16-bit inverter. Applies one of
//  eight bitwise ops (NOT/AND/OR/XOR/NAND/NOR/XNOR/PASS) to WIDTH-bit operands.
//  Accepts one operation per cycle over a valid/ready input and queues results in a
//  DEPTH-entry output FIFO drained by a valid/ready output.
//  Sits between operand sources and ALU/register consumers in the Hack datapath.
// PARAMETERS
//  WIDTH  16  operand/result width in bits, >=1
//  DEPTH  2   output FIFO entries; power of 2, >=2
// PORTS
//  clk_i    in   1                  single clock; all state on rising edge
//  rst_i    in   1                  asynchronous, active-high reset
//  valid_i  in   1                  input op valid
//  ready_o  out  1                  block can accept op this cycle
//  op_i     in   3                  opcode (see BEHAVIOUR)
//  a_i      in   WIDTH              operand A
//  b_i      in   WIDTH              operand B (ignored for NOT/PASS)
//  valid_o  out  1                  data_o holds a result
//  ready_i  in   1                  consumer takes result this cycle
//  data_o   out  WIDTH              head-of-FIFO result
//  count_o  out  $clog2(DEPTH+1)    results currently queued
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers=0, count_o=0, valid_o=0, data_o=0;
//    ready_o=1 in the first cycle after release. Entries in flight are discarded.
//  - Ops: 000 ~a | 001 a&b | 010 a|b | 011 a^b | 100 ~(a&b) | 101 ~(a|b)
//    | 110 ~(a^b) | 111 a. All are pure bitwise over WIDTH bits, no carries.
//  - push = valid_i & ready_o; pop = valid_o & ready_i.
//  - ready_o = (count_o != DEPTH). Depends only on registered state, never on
//    ready_i, so a full FIFO does not accept even when a pop occurs that cycle.
//  - Latency: an op pushed at edge N is visible on data_o/valid_o after edge N,
//    i.e. one cycle. No empty-bypass.
//  - Order: strict FIFO. Write/read pointers wrap modulo DEPTH.
//  - Simultaneous push & pop (0<count<DEPTH): count_o unchanged; both pointers advance.
//  - Empty: valid_o=0, data_o forced to 0. A pop request is ignored.
//  - Full: ready_o=0. valid_i is ignored, and a_i/b_i/op_i may change freely.
//  - valid_o/data_o stay stable while valid_o=1 and ready_i=0.
//  - count_o = pushes - pops since reset; always in 0..DEPTH.
// CONFIGURATION
//  BITWISE_PIPE_FLAGS_EN
//   defined:   adds outputs zr_o (1) and ng_o (1). These are Hack-style flags of the
//              head entry: zr_o = (data_o==0), ng_o = data_o[WIDTH-1].
//              Flags are computed at push and stored per entry, adding 2 bits per
//              FIFO entry. Both are 0 when empty and at reset.
//   undefined: ports zr_o/ng_o and their storage do not exist.
//              All other behaviour is identical.
// TESTING (WIDTH=16, DEPTH=2)
//  1 Reset mid-stream: push 2 ops, assert rst_i between edges -> valid_o, count_o
//    and data_o drop to 0 immediately; ready_o=1 after release.
//  2 op=000, a=16'h0000, then a=16'hAAAA, ready_i=1 -> data_o=16'hFFFF, then
//    16'h5555, each one cycle after push.
//  3 All ops with a=16'h3BF1, b=16'h0F0F -> AND 0B01, OR 3FFF, XOR 34FE, NAND F4FE,
//    NOR C000, XNOR CB01, PASS 3BF1, NOT C40E.
//  4 ready_i=0, push 3 ops -> count_o=2 and ready_o=0 after two pushes; 3rd op not
//    taken. ready_i=1 -> first two results drain in order.
//  5 Full plus ready_i=1 plus valid_i=1 in the same cycle -> pop occurs, push refused,
//    count_o=1. Next cycle ready_o=1 and the push is accepted.
//  6 BITWISE_PIPE_FLAGS_EN: op=011, a=b=16'h8001 -> data_o=0, zr_o=1, ng_o=0;
//    op=000, a=0 -> zr_o=0, ng_o=1.

Source files
------------

// File: rtl/bitwise_pipe.sv
// bitwise_pipe: one bitwise op per cycle into a DEPTH-entry valid/ready result FIFO.
// Optional Hack-style zr_o/ng_o head flags when BITWISE_PIPE_FLAGS_EN is defined.
module bitwise_pipe #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           valid_i,
   output logic                           ready_o,
   input  logic [2:0]                     op_i,
   input  logic [WIDTH-1:0]               a_i,
   input  logic [WIDTH-1:0]               b_i,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [WIDTH-1:0]               data_o,
`ifdef BITWISE_PIPE_FLAGS_EN
   output logic                           zr_o,
   output logic                           ng_o,
`endif
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] result;
   logic             push;
   logic             pop;

   always_comb begin
      result = a_i;
      case (op_i)
         3'b000: result = ~a_i;
         3'b001: result = a_i & b_i;
         3'b010: result = a_i | b_i;
         3'b011: result = a_i ^ b_i;
         3'b100: result = ~(a_i & b_i);
         3'b101: result = ~(a_i | b_i);
         3'b110: result = ~(a_i ^ b_i);
         3'b111: result = a_i;
      endcase
   end

   // Handshake flags depend only on registered occupancy, never on ready_i.
   assign ready_o = (count_q != CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   always_comb begin
      count_d  = count_q + CW'(push) - CW'(pop);
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Entry storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= result;
      end
   end

   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
   assign count_o = count_q;

`ifdef BITWISE_PIPE_FLAGS_EN
   logic zr_q [DEPTH];
   logic ng_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (push) begin
         zr_q[wr_ptr_q] <= (result == '0);
         ng_q[wr_ptr_q] <= result[WIDTH-1];
      end
   end

   assign zr_o = valid_o & zr_q[rd_ptr_q];
   assign ng_o = valid_o & ng_q[rd_ptr_q];
`endif

endmodule
